// File: rtl/lab_dp_pkg.sv
// Shared encodings for the lab register-file datapath: ALU ops, write-back
// sources, operand-A selects, flag bit positions and the control-word layout.
package lab_dp_pkg;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned CE_W     = 4;
  localparam int unsigned W_W      = 3;
  localparam int unsigned S_W      = 3;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned FLAG_W   = 4;

  // Flag register layout {N, Z, C, V}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Index of the flags-update enable inside w
  localparam int unsigned W_FLAGS_BIT = 2;

  typedef enum logic [S_W-1:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_PASSA = 3'b010,
    ALU_PASSB = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_XOR   = 3'b110,
    ALU_NOT   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_F   = 2'b00,
    WB_DIN = 2'b01,
    WB_SHL = 2'b10,
    WB_SHR = 2'b11
  } wb_src_e;

  typedef enum logic [SEL_W-1:0] {
    OPA_DIN = 2'b00,
    OPA_R0  = 2'b01,
    OPA_R2  = 2'b10,
    OPA_R3  = 2'b11
  } opa_sel_e;

  // Per-cycle control word issued by the upstream lab FSM
  typedef struct packed {
    logic             clr;
    logic [CE_W-1:0]  ce;
    logic [W_W-1:0]   w;
    logic [S_W-1:0]   s;
    logic [SEL_W-1:0] sel;
  } ctrl_t;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic n, input logic z,
                                                   input logic c, input logic v);
    return {n, z, c, v};
  endfunction

endpackage

// File: rtl/lab_datapath_if.sv
// Control/data bundle between the lab FSM (master) and the datapath (slave).
interface lab_datapath_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             clr;
  logic [3:0]       ce;
  logic [2:0]       w;
  logic [2:0]       s;
  logic [1:0]       sel;
  logic [WIDTH-1:0] din_a;
  logic [WIDTH-1:0] din_b;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] dout;
  logic [3:0]       flags;

  modport master (
    output clr, ce, w, s, sel, din_a, din_b,
    input  f, dout, flags
  );

  modport slave (
    input  clr, ce, w, s, sel, din_a, din_b,
    output f, dout, flags
  );

endinterface

// File: rtl/dp_alu.sv
// Combinational 8-function ALU with carry and signed-overflow outputs.
// Define ALU_SAT_EN to saturate signed add/sub results on overflow.
module dp_alu
  import lab_dp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [S_W-1:0]   s,
  output logic [WIDTH-1:0] f_c,
  output logic             carry_c,
  output logic             ovf_c
);

  localparam int unsigned MSB = WIDTH - 1;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;

  // Shared adder: subtract is A + ~B + 1
  always_comb begin
    is_sub  = (s == ALU_SUB);
    b_eff   = is_sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    sum_ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
  end

  always_comb begin
    f_c     = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (alu_op_e'(s))
      ALU_ADD, ALU_SUB: begin
        f_c     = sum[WIDTH-1:0];
        carry_c = sum[WIDTH];
        ovf_c   = sum_ovf;
`ifdef ALU_SAT_EN
        // Overflow direction follows the sign shared by both effective operands
        if (sum_ovf) begin
          f_c = a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end
      ALU_PASSA: f_c = a;
      ALU_PASSB: f_c = b;
      ALU_AND:   f_c = a & b;
      ALU_OR:    f_c = a | b;
      ALU_XOR:   f_c = a ^ b;
      ALU_NOT:   f_c = ~a;
    endcase
  end

endmodule

// File: rtl/lab_datapath.sv
// Register-file datapath executing the lab FSM control word: R0..R3, {N,Z,C,V}
// flags, operand mux, ALU and write-back shifter. ALU_SAT_EN selects saturating add/sub.
module lab_datapath
  import lab_dp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  lab_datapath_if.slave bus
);

  ctrl_t             ctrl;
  logic [WIDTH-1:0]  r_q [NUM_REGS];
  logic [WIDTH-1:0]  r_d [NUM_REGS];
  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] flags_d;

  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  alu_f;
  logic              alu_c;
  logic              alu_v;
  logic [WIDTH-1:0]  wb_val;

  assign ctrl = {bus.clr, bus.ce, bus.w, bus.s, bus.sel};

  // Operand A mux; operand B is hard-wired to R1
  always_comb begin
    op_a = bus.din_a;
    case (opa_sel_e'(ctrl.sel))
      OPA_DIN: op_a = bus.din_a;
      OPA_R0:  op_a = r_q[0];
      OPA_R2:  op_a = r_q[2];
      OPA_R3:  op_a = r_q[3];
    endcase
  end

  dp_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a       (op_a),
    .b       (r_q[1]),
    .s       (ctrl.s),
    .f_c     (alu_f),
    .carry_c (alu_c),
    .ovf_c   (alu_v)
  );

  // Write-back shifter
  always_comb begin
    wb_val = alu_f;
    case (wb_src_e'(ctrl.w[1:0]))
      WB_F:   wb_val = alu_f;
      WB_DIN: wb_val = bus.din_b;
      WB_SHL: wb_val = {alu_f[WIDTH-2:0], 1'b0};
      WB_SHR: wb_val = {1'b0, alu_f[WIDTH-1:1]};
    endcase
  end

  // Next state: clear beats writes; flags track f, independent of ce
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      r_d[i] = r_q[i];
    end
    flags_d = flags_q;
    if (ctrl.clr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_d[i] = '0;
      end
      flags_d = '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ctrl.ce[i]) begin
          r_d[i] = wb_val;
        end
      end
      if (ctrl.w[W_FLAGS_BIT]) begin
        flags_d = pack_flags(alu_f[WIDTH-1], alu_f == '0, alu_c, alu_v);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_q[i] <= '0;
      end
      flags_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_q[i] <= r_d[i];
      end
      flags_q <= flags_d;
    end
  end

  assign bus.f     = alu_f;
  assign bus.dout  = r_q[3];
  assign bus.flags = flags_q;

endmodule
